// File: rtl/tpram_dp_pkg.sv
// Shared defaults for the true dual-port RAM: the 2 KB x 8 history buffer geometry.
package tpram_dp_pkg;

  localparam int TPRAM_AW = 11;
  localparam int TPRAM_DW = 8;

endpackage

// File: rtl/tpram_dp_port.sv
// One RAM port: registered read address (async reset to 0) and output-enable mux.
module tpram_dp_port #(
  parameter int aw = 11,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          oe,
  input  logic [aw-1:0] addr,
  input  logic [dw-1:0] rdata,
  output logic [aw-1:0] ra,
  output logic [dw-1:0] dout
);

  logic [aw-1:0] ra_d;
  logic [aw-1:0] ra_q;

  always_comb begin
    ra_d = ra_q;
    if (ce) begin
      ra_d = addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q <= '0;
    end else begin
      ra_q <= ra_d;
    end
  end

  assign ra = ra_q;
  // Output is forced to zero rather than floating when not enabled.
  assign dout = oe ? rdata : '0;

endmodule

// File: rtl/tpram_dp.sv
// True dual-port RAM, single clock. Reads go through a registered address, so a
// write at edge N is visible on either port after edge N (write-first).
module tpram_dp
  import tpram_dp_pkg::*;
#(
  parameter int aw = TPRAM_AW,
  parameter int dw = TPRAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_a,
  input  logic          we_a,
  input  logic          oe_a,
  input  logic [aw-1:0] addr_a,
  input  logic [dw-1:0] di_a,
  output logic [dw-1:0] do_a,
  input  logic          ce_b,
  input  logic          we_b,
  input  logic          oe_b,
  input  logic [aw-1:0] addr_b,
  input  logic [dw-1:0] di_b,
  output logic [dw-1:0] do_b
);

  logic [dw-1:0] mem [0:(2**aw)-1];
  logic [aw-1:0] ra_a;
  logic [aw-1:0] ra_b;

  // Port B's write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (ce_a && we_a) begin
      mem[addr_a] <= di_a;
    end
    if (ce_b && we_b) begin
      mem[addr_b] <= di_b;
    end
  end

  tpram_dp_port #(.aw(aw), .dw(dw)) u_port_a (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce_a),
    .oe    (oe_a),
    .addr  (addr_a),
    .rdata (mem[ra_a]),
    .ra    (ra_a),
    .dout  (do_a)
  );

  tpram_dp_port #(.aw(aw), .dw(dw)) u_port_b (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce_b),
    .oe    (oe_b),
    .addr  (addr_b),
    .rdata (mem[ra_b]),
    .ra    (ra_b),
    .dout  (do_b)
  );

endmodule

// File: tb/tb_tpram_dp.sv
// Bench for tpram_dp: directed scenarios plus random traffic against an array model.
module tb_tpram_dp;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic rst;
  logic ce_a, we_a, oe_a, ce_b, we_b, oe_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] di_a, di_b, do_a, do_b;

  always #5 clk = ~clk;

  tpram_dp #(.aw(AW), .dw(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce_a   (ce_a),
    .we_a   (we_a),
    .oe_a   (oe_a),
    .addr_a (addr_a),
    .di_a   (di_a),
    .do_a   (do_a),
    .ce_b   (ce_b),
    .we_b   (we_b),
    .oe_b   (oe_b),
    .addr_b (addr_b),
    .di_b   (di_b),
    .do_b   (do_b)
  );

  // Reference model: contents, which words are known, and each port's read address.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_vld [DEPTH];
  int            ref_ra_a;
  int            ref_ra_b;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (!oe_a) check("do_a_off", do_a, '0);
    else if (ref_vld[ref_ra_a]) check("do_a", do_a, ref_mem[ref_ra_a]);
    if (!oe_b) check("do_b_off", do_b, '0);
    else if (ref_vld[ref_ra_b]) check("do_b", do_b, ref_mem[ref_ra_b]);
  endtask

  // One clock: update the model from the inputs present at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ref_ra_a = 0;
      ref_ra_b = 0;
    end else begin
      if (ce_a && we_a) begin ref_mem[addr_a] = di_a; ref_vld[addr_a] = 1'b1; end
      if (ce_b && we_b) begin ref_mem[addr_b] = di_b; ref_vld[addr_b] = 1'b1; end
      if (ce_a) ref_ra_a = int'(addr_a);
      if (ce_b) ref_ra_b = int'(addr_b);
    end
    #1;
    check_outputs();
  endtask

  task automatic wr_a(input int addr, input logic [DW-1:0] data);
    ce_a = 1'b1; we_a = 1'b1; addr_a = AW'(addr); di_a = data;
    step();
    ce_a = 1'b0; we_a = 1'b0;
  endtask

  task automatic rd_b(input int addr);
    ce_b = 1'b1; we_b = 1'b0; addr_b = AW'(addr);
    step();
    ce_b = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_v;
    for (int i = 0; i < DEPTH; i++) begin ref_vld[i] = 1'b0; ref_mem[i] = '0; end
    ref_ra_a = 0; ref_ra_b = 0;
    rst = 1'b1;
    ce_a = 1'b0; we_a = 1'b0; oe_a = 1'b0; addr_a = '0; di_a = '0;
    ce_b = 1'b0; we_b = 1'b0; oe_b = 1'b0; addr_b = '0; di_b = '0;

    // Reset state and oe gating
    step();
    check("reset_do_a", do_a, 8'h00);
    check("reset_do_b", do_b, 8'h00);
    rst = 1'b0;
    wr_a(0, 8'h11);
    wr_a(5, 8'h55);
    oe_a = 1'b1;
    #1;
    check("ra_a_loaded", do_a, 8'h55);
    rst = 1'b1;
    #1;
    ref_ra_a = 0; ref_ra_b = 0;
    check("rst_async", do_a, 8'h11);
    ce_a = 1'b1; addr_a = AW'(5);
    step();
    check("rst_hold", do_a, 8'h11);
    oe_a = 1'b0;
    #1;
    check("oe_gate", do_a, 8'h00);
    oe_a = 1'b1;
    #1;
    check("oe_rise", do_a, 8'h11);
    ce_a = 1'b0;
    rst = 1'b0;

    // Basic write A / read B
    oe_b = 1'b1;
    wr_a(12'h123, 8'hA5);
    rd_b(12'h123);
    check("basic", do_b, 8'hA5);

    // Full sweep: B reads the word A wrote on the previous edge
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        ce_a = 1'b1; we_a = 1'b1; addr_a = AW'(i); di_a = DW'(i) ^ 8'h5A;
      end else begin
        ce_a = 1'b0; we_a = 1'b0;
      end
      if (i > 0) begin ce_b = 1'b1; addr_b = AW'(i - 1); end
      step();
      if (i > 0) begin
        exp_v = DW'(i - 1) ^ 8'h5A;
        check("sweep", do_b, exp_v);
      end
    end
    ce_a = 1'b0; we_a = 1'b0; ce_b = 1'b0;

    // Write-first, cross port, and same-address collision
    wr_a(12'h010, 8'h33);
    rd_b(12'h010);
    check("wf_pre", do_b, 8'h33);
    wr_a(12'h010, 8'h77);
    check("wf_cross", do_b, 8'h77);
    check("wf_same", do_a, 8'h77);
    ce_a = 1'b1; we_a = 1'b1; addr_a = AW'(12'h030); di_a = 8'h01;
    ce_b = 1'b1; we_b = 1'b1; addr_b = AW'(12'h030); di_b = 8'h02;
    step();
    ce_a = 1'b0; we_a = 1'b0; ce_b = 1'b0; we_b = 1'b0;
    check("b_wins_a", do_a, 8'h02);
    check("b_wins_b", do_b, 8'h02);

    // ce hold: address holds and writes are blocked
    wr_a(12'h020, 8'h44);
    wr_a(12'h021, 8'h99);
    rd_b(12'h020);
    check("ce_load", do_b, 8'h44);
    ce_b = 1'b0; we_b = 1'b1; addr_b = AW'(12'h021); di_b = 8'hEE;
    step();
    check("ce_hold", do_b, 8'h44);
    we_b = 1'b0;
    rd_b(12'h021);
    check("ce_nowrite", do_b, 8'h99);

    // Decoder-style stream
    wr_a(0, 8'h41);
    wr_a(1, 8'h42);
    wr_a(2, 8'h43);
    for (int k = 0; k < 3; k++) begin
      rd_b(k);
      exp_v = 8'h41 + DW'(k);
      check("stream", do_b, exp_v);
    end

    // Random traffic over a small window to force collisions
    for (int n = 0; n < 600; n++) begin
      ce_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
      oe_a = 1'($urandom_range(0, 3) != 0);
      addr_a = AW'($urandom_range(0, 15)); di_a = DW'($urandom);
      ce_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
      oe_b = 1'($urandom_range(0, 3) != 0);
      addr_b = AW'($urandom_range(0, 15)); di_b = DW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpram_dp.md
Name: tpram_dp

Overview:
- Generic true dual-port RAM: two independent read/write ports (A and B) share one storage array of 2**aw words of dw bits.
- Used as the 2 KB LZS decompressor history buffer: port A writes decoded bytes, port B reads back-referenced bytes.
- Both ports run on a single clock, clk, and a single reset, rst.

Parameters:
- aw, 11, address width in bits; depth is 2**aw words.
- dw, 8, data width in bits.

Ports:
- clk  in  1  clock, shared by both ports; all sequential logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- ce_a  in  1  port A enable; gates writes and address capture.
- we_a  in  1  port A write enable; effective only when ce_a=1.
- oe_a  in  1  port A output enable.
- addr_a  in  aw  port A address.
- di_a  in  dw  port A write data.
- do_a  out  dw  port A read data.
- ce_b  in  1  port B enable.
- we_b  in  1  port B write enable.
- oe_b  in  1  port B output enable.
- addr_b  in  aw  port B address.
- di_b  in  dw  port B write data.
- do_b  out  dw  port B read data.

Behaviour:
- Storage: mem[0 .. 2**aw-1], dw bits wide. It is not initialised and not cleared by rst; contents are undefined until written.
- Write, per port X in {a,b}: at the rising edge of clk, if ce_x=1 and we_x=1 then mem[addr_x] <= di_x.
- Address register, per port X: ra_x. At the rising edge, if ce_x=1 then ra_x <= addr_x; otherwise ra_x holds.
- rst asserted (asynchronous): ra_a and ra_b go to 0 immediately. Memory is untouched.
- Read data: do_x = oe_x ? mem[ra_x] : 0.
  - This is a combinational read through the registered address.
  - do_x tracks oe_x combinationally with no added latency.
- Read latency: one clock from addr_x to do_x. Present addr at edge N; data is valid after edge N, while oe_x=1.
- Reset value of outputs:
  - do_x = mem[0] if oe_x=1 (undefined until written).
  - do_x = 0 if oe_x=0.
- Read-during-write, same port, same address: after the edge, do_x shows the newly written data (write-first).
- Cross-port read-during-write: port A writes address k at edge N while ra_b = k. do_b shows the new data after edge N.
- Simultaneous write, both ports to the same address in the same edge: port B's data is stored (B wins). Writes to different addresses both occur.
- ce_x=0: no write, and ra_x holds, so do_x keeps showing mem[ra_x]. That value reflects any later writes to that address.
- Address wrap: addresses are aw bits; no out-of-range access exists.
- X/Z policy: none. The outputs never float.

Decomposition:
- No shared package needed; aw and dw are the module parameters.
- A single module with no sub-modules.
- The storage array is inferable as block RAM.
- Optional: a per-port helper "tpram_port" holding the address register and output mux. Not required.

Test Plan:
- Reset/oe gating:
  - Assert rst with ce_a=1 and addr_a=5, write 0x11 to addr 0 via port A, then release rst.
  - With oe_a=0, do_a=0x00. Raise oe_a: do_a=0x11 after ra_a is reloaded with 0.
  - Confirm that ra_a returns to 0 immediately when rst is asserted asynchronously.
- Basic write A / read B:
  - Port A writes 0xA5 to addr 0x123.
  - Next cycle, port B sets addr_b=0x123 with oe_b=1.
  - One edge later, do_b=0xA5.
- Full sweep:
  - Port A writes data = addr[7:0] ^ 0x5A to all 2048 addresses.
  - Port B reads them back sequentially; each do_b equals the expected value one cycle after its address.
- Write-first collision:
  - ra_b=0x010, holding 0x33. Port A writes 0x77 to 0x010 at edge N.
  - do_b=0x77 after edge N.
  - Same-address write on both ports at once (A=0x01, B=0x02): a subsequent read returns 0x02.
- ce hold:
  - Load addr_b=0x020 (holding 0x44) with ce_b=1.
  - Drop ce_b and change addr_b to 0x021: do_b stays 0x44.
  - With we_b=1 and ce_b=0, mem[0x021] is unchanged.
- Decoder-style stream:
  - Write bytes 0x41,0x42,0x43 to addr 0,1,2.
  - Port B increments its address 0→2, one per clock, with oe_b=1.
  - do_b gives 0x41,0x42,0x43 on consecutive cycles.
